// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_e;

  localparam int unsigned RF_ZERO_IDX = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned READ_PORTS    = 2
) (
  input  logic                                iClk,
  input  logic                                iRst,
  input  logic                                flush,
  input  logic                                set_en,
  input  logic [ADDRESS_WIDTH-1:0]            set_addr,
  input  logic                                clr_en,
  input  logic [ADDRESS_WIDTH-1:0]            clr_addr,
  input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] read_addr,
  output logic [READ_PORTS-1:0]               busy
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DEPTH-1:0] sb;

  // Bit 0 is only ever loaded by reset/flush, so it stays 0.
  // Set is checked before clear so a same-cycle reissue keeps the register pending.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sb <= '0;
    end else if (flush) begin
      sb <= '0;
    end else begin
      for (int unsigned r = RF_ZERO_IDX + 1; r < DEPTH; r++) begin
        if (set_en && set_addr == ADDRESS_WIDTH'(r)) begin
          sb[r] <= 1'b1;
        end else if (clr_en && clr_addr == ADDRESS_WIDTH'(r)) begin
          sb[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      busy[p] = sb[read_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Decode-stage integer register file: async read ports with write bypass,
// one sync write port, x0 hardwired to zero, pending-write scoreboard and clear engine.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned READ_PORTS    = 2,
  parameter int unsigned BYPASS        = 1
) (
  input  logic                                iClk,
  input  logic                                iRst,
  input  logic                                iWriteEn,
  input  logic [ADDRESS_WIDTH-1:0]            iWriteAddress,
  input  logic [DATA_WIDTH-1:0]               iDataIn,
  input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] iReadAddress,
  output logic [READ_PORTS*DATA_WIDTH-1:0]    oRegData,
  output logic [READ_PORTS-1:0]               oBusy,
  input  logic                                iIssueEn,
  input  logic [ADDRESS_WIDTH-1:0]            iIssueAddress,
  input  logic                                iClearReq,
  output logic                                oReady
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(RF_ZERO_IDX);
  localparam logic [ADDRESS_WIDTH-1:0] FIRST_IDX = ADDRESS_WIDTH'(1);

  rf_state_e               state;
  logic [ADDRESS_WIDTH-1:0] clr_idx;
  logic                     ready_q;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]    mem_wdata;

  logic                     running;
  logic                     accept;
  logic [READ_PORTS-1:0]    sb_busy;

  assign running = (state == RF_RUN);
  // A clear request in RUN drops any same-cycle write or issue.
  assign accept  = running && !iClearReq;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= RF_CLEAR;
      clr_idx <= FIRST_IDX;
      ready_q <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          clr_idx <= clr_idx + FIRST_IDX;
          if (clr_idx == '1) begin
            state   <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN: begin
          if (iClearReq) begin
            state   <= RF_CLEAR;
            clr_idx <= FIRST_IDX;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= RF_CLEAR;
          clr_idx <= FIRST_IDX;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign oReady = ready_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = iWriteAddress;
    mem_wdata = iDataIn;
    if (!running) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx;
      mem_wdata = '0;
    end else if (accept && iWriteEn && iWriteAddress != ZERO_ADDR) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the array so it maps onto RAM; the clear engine zeroes it instead.
  always_ff @(posedge iClk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  regfile_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .READ_PORTS    (READ_PORTS)
  ) u_scoreboard (
    .iClk      (iClk),
    .iRst      (iRst),
    .flush     (running && iClearReq),
    .set_en    (accept && iIssueEn),
    .set_addr  (iIssueAddress),
    .clr_en    (accept && iWriteEn),
    .clr_addr  (iWriteAddress),
    .read_addr (iReadAddress),
    .busy      (sb_busy)
  );

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     write_hit;
    logic                     issue_hit;
    logic [DATA_WIDTH-1:0]    rd;

    assign addr      = iReadAddress[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign write_hit = (BYPASS != 0) && iWriteEn && (iWriteAddress == addr);
    assign issue_hit = iIssueEn && (iIssueAddress == addr);

    always_comb begin
      rd = '0;
      if (running && addr != ZERO_ADDR) begin
        rd = write_hit ? iDataIn : mem[addr];
      end
    end

    assign oRegData[p*DATA_WIDTH +: DATA_WIDTH] = rd;
    // A bypassed write hides the hazard unless the same cycle reissues to it.
    assign oBusy[p] = running && sb_busy[p] && !(write_hit && !issue_hit);
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: directed scenarios plus random traffic vs. a behavioural model.
module tb_regfile_multiport;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned RP    = 2;
  localparam int unsigned BYP   = 1;
  localparam int unsigned DEPTH = 32;

  logic              iClk = 1'b0;
  logic              iRst = 1'b1;
  logic              iWriteEn = 1'b0;
  logic [AW-1:0]     iWriteAddress = '0;
  logic [DW-1:0]     iDataIn = '0;
  logic [RP*AW-1:0]  iReadAddress = '0;
  logic [RP*DW-1:0]  oRegData;
  logic [RP-1:0]     oBusy;
  logic              iIssueEn = 1'b0;
  logic [AW-1:0]     iIssueAddress = '0;
  logic              iClearReq = 1'b0;
  logic              oReady;

  always #5 iClk = ~iClk;

  regfile_multiport #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .READ_PORTS    (RP),
    .BYPASS        (BYP)
  ) dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iWriteEn      (iWriteEn),
    .iWriteAddress (iWriteAddress),
    .iDataIn       (iDataIn),
    .iReadAddress  (iReadAddress),
    .oRegData      (oRegData),
    .oBusy         (oBusy),
    .iIssueEn      (iIssueEn),
    .iIssueAddress (iIssueAddress),
    .iClearReq     (iClearReq),
    .oReady        (oReady)
  );

  typedef struct packed {
    logic              ready;
    logic [RP*DW-1:0]  data;
    logic [RP-1:0]     busy;
    logic [31:0]       id;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural register contents, pending bits, and edges left until ready.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_sb  [DEPTH];
  bit            m_ready = 1'b0;
  int            m_left  = DEPTH - 1;
  int unsigned   cyc = 0;

  function automatic void model_restart();
    m_ready = 1'b0;
    m_left  = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_sb[i]  = 1'b0;
    end
  endfunction

  task automatic step(input bit rst, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                      input bit ie, input logic [AW-1:0] ia, input bit clr);
    exp_t          e;
    logic [AW-1:0] ra [RP];
    bit            hit;
    ra[0] = ra0;
    ra[1] = ra1;
    iRst          = rst;
    iWriteEn      = we;
    iWriteAddress = wa;
    iDataIn       = wd;
    iReadAddress  = {ra1, ra0};
    iIssueEn      = ie;
    iIssueAddress = ia;
    iClearReq     = clr;

    e.ready = !rst && m_ready;
    e.data  = '0;
    e.busy  = '0;
    e.id    = cyc;
    if (e.ready) begin
      for (int p = 0; p < RP; p++) begin
        hit = (BYP != 0) && we && (wa == ra[p]);
        if (ra[p] != 0) e.data[p*DW +: DW] = hit ? wd : m_mem[ra[p]];
        e.busy[p] = m_sb[ra[p]] && !(hit && !(ie && ia == ra[p]));
      end
    end
    exp_q.push_back(e);

    if (rst) begin
      model_restart();
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else if (clr) begin
      model_restart();
    end else begin
      if (we && wa != 0) m_mem[wa] = wd;
      if (we) m_sb[wa] = 1'b0;
      if (ie && ia != 0) m_sb[ia] = 1'b1;
    end

    @(posedge iClk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    step(1'b0, 1'b0, '0, '0, ra0, ra1, 1'b0, '0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] id, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, id, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ready", e.id, 64'(oReady), 64'(e.ready));
        for (int p = 0; p < RP; p++) begin
          chk($sformatf("rdata%0d", p), e.id, 64'(oRegData[p*DW +: DW]), 64'(e.data[p*DW +: DW]));
          chk($sformatf("busy%0d", p), e.id, 64'(oBusy[p]), 64'(e.busy[p]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] wa, ra0, ra1, ia;
    model_restart();
    @(posedge iClk);
    #1;

    // Reset release and readiness latency.
    repeat (3) step(1'b1, 1'b0, '0, '0, 5'd3, 5'd9, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) idle(AW'(i), AW'(DEPTH - 1 - i));
    for (int i = 0; i < DEPTH; i++) idle(AW'(i), AW'(DEPTH - 1 - i));

    // Write with same-cycle bypass.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, '0, 1'b0);
    idle(5'd5, 5'd5);

    // x0 stays zero and never busy.
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    idle(5'd0, 5'd0);

    // Scoreboard set / set-wins / clear.
    step(1'b0, 1'b0, '0, '0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
    idle(5'd7, 5'd7);
    idle(5'd7, 5'd7);
    step(1'b0, 1'b1, 5'd7, 32'h0000_0777, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
    idle(5'd7, 5'd7);
    step(1'b0, 1'b1, 5'd7, 32'h0000_0778, 5'd7, 5'd7, 1'b0, '0, 1'b0);
    idle(5'd7, 5'd7);

    // Fill, then clear request with a concurrent write that must be dropped.
    for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, AW'(i), DW'(i), AW'(i), AW'(i - 1), 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) idle(AW'(i), AW'(DEPTH - 1 - i));
    step(1'b0, 1'b1, 5'd3, 32'h55, 5'd4, 5'd5, 1'b1, 5'd6, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) idle(5'd3, AW'(i));
    for (int i = 0; i < DEPTH; i++) idle(AW'(i), 5'd3);

    // Reset in the middle of a clear sweep.
    step(1'b0, 1'b0, '0, '0, 5'd9, 5'd12, 1'b1, 5'd9, 1'b0);
    step(1'b0, 1'b0, '0, '0, 5'd9, 5'd12, 1'b1, 5'd12, 1'b0);
    idle(5'd9, 5'd12);
    step(1'b0, 1'b0, '0, '0, 5'd9, 5'd12, 1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) idle(5'd9, 5'd12);
    repeat (2) step(1'b1, 1'b0, '0, '0, 5'd9, 5'd12, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) idle(5'd9, 5'd12);
    idle(5'd9, 5'd12);
    for (int i = 0; i < DEPTH; i++) idle(AW'(i), AW'(i));

    // Random traffic over a narrow address window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      wa  = AW'($urandom_range(0, 7));
      ia  = AW'($urandom_range(0, 7));
      ra0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? ia : AW'($urandom_range(0, 7));
      step(1'b0, 1'($urandom_range(0, 1)), wa, DW'($urandom), ra0, ra1,
           ($urandom_range(0, 9) < 3), ia, ($urandom_range(0, 99) == 0));
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge iClk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
